// File: rtl/simple_alu_pkg.sv
// Shared opcode encoding for the simple_alu datapath.
// Optional flag outputs are enabled with the SIMPLE_ALU_FLAGS_EN macro.
package simple_alu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_SHL = 3'd2,
    OP_SHR = 3'd3,
    OP_AND = 3'd4,
    OP_OR  = 3'd5,
    OP_XOR = 3'd6,
    OP_EQ  = 3'd7
  } alu_op_e;

endpackage

// File: rtl/simple_alu_core.sv
// Combinational next-result logic for simple_alu.
// With SIMPLE_ALU_FLAGS_EN the next zero and carry/borrow flags are produced too.
module simple_alu_core
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
`ifdef SIMPLE_ALU_FLAGS_EN
  output logic             zero_o,
  output logic             carry_o,
`endif
  output logic [WIDTH-1:0] res_o
);

  localparam logic [WIDTH-1:0] WIDTH_V = WIDTH'(WIDTH);

  alu_op_e          op;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] diff;
  logic             shift_oob;

  assign op        = alu_op_e'(op_i);
  assign shift_oob = (b_i >= WIDTH_V);

`ifdef SIMPLE_ALU_FLAGS_EN
  // One extra bit holds the carry-out of ADD and the borrow (a<b) of SUB.
  logic [WIDTH:0] add_x;
  logic [WIDTH:0] sub_x;

  assign add_x = {1'b0, a_i} + {1'b0, b_i};
  assign sub_x = {1'b0, a_i} - {1'b0, b_i};
  assign sum   = add_x[WIDTH-1:0];
  assign diff  = sub_x[WIDTH-1:0];

  always_comb begin
    carry_o = 1'b0;
    case (op)
      OP_ADD:  carry_o = add_x[WIDTH];
      OP_SUB:  carry_o = sub_x[WIDTH];
      default: carry_o = 1'b0;
    endcase
  end

  assign zero_o = (res_o == '0);
`else
  assign sum  = a_i + b_i;
  assign diff = a_i - b_i;
`endif

  always_comb begin
    res_o = '0;
    case (op)
      OP_ADD: res_o = sum;
      OP_SUB: res_o = diff;
      OP_SHL: res_o = shift_oob ? '0 : (a_i << b_i);
      OP_SHR: res_o = shift_oob ? '0 : (a_i >> b_i);
      OP_AND: res_o = a_i & b_i;
      OP_OR:  res_o = a_i | b_i;
      OP_XOR: res_o = a_i ^ b_i;
      OP_EQ:  res_o = {{(WIDTH-1){1'b0}}, (a_i == b_i)};
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/simple_alu.sv
// Registered 8-op integer ALU: simple_alu_core followed by an async-reset output register.
// Defining SIMPLE_ALU_FLAGS_EN adds registered zero_o and carry_o outputs.
module simple_alu
  import simple_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic [OP_W-1:0]  op_i,
`ifdef SIMPLE_ALU_FLAGS_EN
  output logic             zero_o,
  output logic             carry_o,
`endif
  output logic [WIDTH-1:0] alu_o
);

  logic [WIDTH-1:0] alu_d;
  logic [WIDTH-1:0] alu_q;

`ifdef SIMPLE_ALU_FLAGS_EN
  logic zero_d, zero_q;
  logic carry_d, carry_q;
`endif

  simple_alu_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
`ifdef SIMPLE_ALU_FLAGS_EN
    .zero_o  (zero_d),
    .carry_o (carry_d),
`endif
    .res_o   (alu_d)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      alu_q <= '0;
    end else begin
      alu_q <= alu_d;
    end
  end

  assign alu_o = alu_q;

`ifdef SIMPLE_ALU_FLAGS_EN
  // Zero reads as set while in reset, matching the cleared result.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_q  <= 1'b1;
      carry_q <= 1'b0;
    end else begin
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign zero_o  = zero_q;
  assign carry_o = carry_q;
`endif

endmodule

// File: tb/tb_simple_alu.sv
// Self-checking bench for simple_alu (WIDTH=8): directed vectors plus randomized traffic
// compared every cycle against an arithmetic reference model. Honors SIMPLE_ALU_FLAGS_EN.
module tb_simple_alu;

  localparam int W    = 8;
  localparam int MASK = (1 << W) - 1;

  logic         clk_i;
  logic         rst_ni;
  logic [W-1:0] a_i;
  logic [W-1:0] b_i;
  logic [2:0]   op_i;
  logic [W-1:0] alu_o;
`ifdef SIMPLE_ALU_FLAGS_EN
  logic         zero_o;
  logic         carry_o;
`endif

  int tests;
  int fails;
  bit cmp_en;

  int exp_res;
  bit exp_carry;

  simple_alu #(
    .WIDTH (W)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .a_i     (a_i),
    .b_i     (b_i),
    .op_i    (op_i),
`ifdef SIMPLE_ALU_FLAGS_EN
    .zero_o  (zero_o),
    .carry_o (carry_o),
`endif
    .alu_o   (alu_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference: unsigned integer arithmetic reduced modulo 2^W.
  function automatic void model(input int a, input int b, input int op,
                                output int res, output bit c);
    res = 0;
    c   = 1'b0;
    case (op)
      0: begin res = (a + b) & MASK; c = ((a + b) > MASK); end
      1: begin res = (a - b) & MASK; c = (a < b); end
      2: res = (b >= W) ? 0 : ((a << b) & MASK);
      3: res = (b >= W) ? 0 : (a >> b);
      4: res = a & b;
      5: res = a | b;
      6: res = a ^ b;
      default: res = (a == b) ? 1 : 0;
    endcase
  endfunction

  task automatic check(input string name, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  // Model register: mirrors what alu_o must hold after each edge.
  always @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      exp_res   <= 0;
      exp_carry <= 1'b0;
    end else begin
      int r;
      bit c;
      model(int'(a_i), int'(b_i), int'(op_i), r, c);
      exp_res   <= r;
      exp_carry <= c;
    end
  end

  // Continuous comparison away from the active edge.
  always @(negedge clk_i) begin
    if (cmp_en) begin
      check("model_alu", int'(alu_o), exp_res);
`ifdef SIMPLE_ALU_FLAGS_EN
      check("model_zero", int'(zero_o), (exp_res == 0) ? 1 : 0);
      check("model_carry", int'(carry_o), int'(exp_carry));
`endif
    end
  end

  // Apply a vector at the falling edge, check the result just after the next rising edge.
  task automatic apply(input string name, input int a, input int b, input int op,
                       input int req, input int req_carry);
    int r;
    bit c;
    @(negedge clk_i);
    a_i  = W'(a);
    b_i  = W'(b);
    op_i = 3'(op);
    model(a, b, op, r, c);
    check({name, "_model"}, r, req);
    @(posedge clk_i);
    #1;
    check(name, int'(alu_o), req);
    $display("[TB] %-8s a=%0d b=%0d op=%0d -> alu=%0d", name, a, b, op, alu_o);
`ifdef SIMPLE_ALU_FLAGS_EN
    check({name, "_zero"}, int'(zero_o), (req == 0) ? 1 : 0);
    check({name, "_carry"}, int'(carry_o), req_carry);
`else
    if (req_carry < 0) check({name, "_carry_arg"}, req_carry, 0);
`endif
  endtask

  initial begin
    tests  = 0;
    fails  = 0;
    cmp_en = 1'b0;
    rst_ni = 1'b0;
    a_i    = 8'd5;
    b_i    = 8'd3;
    op_i   = 3'd0;

    // Reset held across edges keeps the output cleared.
    repeat (3) @(posedge clk_i);
    #1;
    check("reset_hold", int'(alu_o), 0);
`ifdef SIMPLE_ALU_FLAGS_EN
    check("reset_zero", int'(zero_o), 1);
    check("reset_carry", int'(carry_o), 0);
`endif
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    check("first_capture", int'(alu_o), 8);
    $display("[TB] reset release -> alu=%0d", alu_o);

    // Mid-cycle reset clears the output without a clock edge.
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_reset", int'(alu_o), 0);
    $display("[TB] async reset -> alu=%0d", alu_o);
    @(negedge clk_i);
    rst_ni = 1'b1;
    cmp_en = 1'b1;

    apply("add",     5,    3,    0, 8,    0);
    apply("sub",     5,    3,    1, 2,    0);
    apply("add_wrap", 255, 1,    0, 0,    1);
    apply("sub_wrap", 3,   5,    1, 254,  1);
    apply("shl",     5,    2,    2, 20,   0);
    apply("shr",     8,    2,    3, 2,    0);
    apply("shl_oob", 255,  8,    2, 0,    0);
    apply("shr_oob", 128,  9,    3, 0,    0);
    apply("and",     240,  15,   4, 0,    0);
    apply("or",      240,  15,   5, 255,  0);
    apply("xor",     240,  15,   6, 255,  0);
    apply("eq_t",    7,    7,    7, 1,    0);
    apply("eq_f",    7,    9,    7, 0,    0);

    // Back-to-back sweep through every opcode.
    apply("b2b_add", 12,   3,    0, 15,   0);
    apply("b2b_sub", 12,   3,    1, 9,    0);
    apply("b2b_shl", 12,   3,    2, 96,   0);
    apply("b2b_shr", 12,   3,    3, 1,    0);
    apply("b2b_and", 12,   3,    4, 0,    0);
    apply("b2b_or",  12,   3,    5, 15,   0);
    apply("b2b_xor", 12,   3,    6, 15,   0);
    apply("b2b_eq",  12,   3,    7, 0,    0);

    // Randomized traffic; the continuous compare does the checking.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_i);
      a_i  = W'($urandom);
      b_i  = ($urandom_range(0, 1) == 1) ? W'($urandom_range(0, 10)) : W'($urandom);
      if ($urandom_range(0, 15) == 0) b_i = a_i;
      op_i = 3'($urandom_range(0, 7));
      if (i == 200) begin
        rst_ni = 1'b0;
        #1;
        check("rand_reset", int'(alu_o), 0);
        rst_ni = 1'b1;
      end
    end
    @(negedge clk_i);
    cmp_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
